// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter
//   Shares one combinational cost ROM (W,J -> Cost) among NREQ search engines.
//   Bursts of BURST reads are granted round-robin as a whole. W/J are
//   registered, and each returned Cost comes back one edge later, tagged with a
//   one-hot valid that names its owner.
//   Optional build macro: JAM_ARB_ABORT_EN. When it is defined, an owner that
//   drops req during its burst ends the burst early. When it is undefined,
//   every burst runs exactly BURST reads.
module jam_cost_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] rd_w,
    input  logic [3*NREQ-1:0] rd_j,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        beat,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [6:0]        Cost,
    output logic [6:0]        cost_out,
    output logic [NREQ-1:0]   cost_vld,
    output logic              busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [2:0] LP_LAST_BEAT = 3'(BURST - 1);
    localparam logic [2:0] LP_LAST_INIT = 3'(NREQ - 1);

    state_t            r_state;
    state_t            w_state_nxt;

    // r_last is both the round-robin pointer and the index of the current owner
    logic [2:0]        r_last;
    logic [NREQ-1:0]   r_gnt;
    logic [2:0]        r_beat;
    logic [2:0]        r_w;
    logic [2:0]        r_j;
    logic [2:0]        r_tag;
    logic              r_tag_vld;
    logic [6:0]        r_cost;
    logic [NREQ-1:0]   r_cost_vld;

    logic              w_found;
    logic [2:0]        w_win_idx;
    logic [NREQ-1:0]   w_win_onehot;
    logic [2:0]        w_sel_w;
    logic [2:0]        w_sel_j;
    logic [NREQ-1:0]   w_tag_onehot;
    logic              w_last_beat;
    logic              w_abort;
    logic              w_busy;

    // Round-robin winner: the first requester found searching last+1, last+2, ... mod NREQ
    always_comb begin
        w_found      = 1'b0;
        w_win_idx    = r_last;
        w_win_onehot = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!w_found && req[i] && (((32'(r_last) + k) % NREQ) == i)) begin
                    w_found         = 1'b1;
                    w_win_idx       = 3'(i);
                    w_win_onehot    = '0;
                    w_win_onehot[i] = 1'b1;
                end
            end
        end
    end

    // Select the address pair driven by the current owner
    always_comb begin
        w_sel_w = '0;
        w_sel_j = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_last == 3'(i)) begin
                w_sel_w = rd_w[3*i +: 3];
                w_sel_j = rd_j[3*i +: 3];
            end
        end
    end

    // Decode the in-flight tag into the owner's one-hot valid
    always_comb begin
        w_tag_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_tag_onehot[i] = (r_tag == 3'(i));
        end
    end

    assign w_last_beat = (r_beat == LP_LAST_BEAT);

`ifdef JAM_ARB_ABORT_EN
    logic w_owner_req;

    // The owner's level request; losing it in BURST cancels the rest of the burst
    always_comb begin
        w_owner_req = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_last == 3'(i)) begin
                w_owner_req = req[i];
            end
        end
    end

    assign w_abort = (r_state == S_BURST) && !w_owner_req;
`else
    assign w_abort = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: grant on any request, and return to IDLE after the terminal beat or an abort
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_abort || w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_busy = (r_state == S_BURST);
    end

    // Grant, beat counter and round-robin pointer
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_gnt  <= '0;
            r_beat <= '0;
            r_last <= LP_LAST_INIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt  <= w_win_onehot;
                        r_last <= w_win_idx;
                        r_beat <= '0;
                    end
                end
                S_BURST: begin
                    if (w_abort || w_last_beat) begin
                        r_gnt  <= '0;
                        r_beat <= '0;
                    end else begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
                default: begin
                    r_gnt  <= '0;
                    r_beat <= '0;
                end
            endcase
        end
    end

    // ROM address sample: once per burst edge, unless the burst is being aborted
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_w       <= '0;
            r_j       <= '0;
            r_tag     <= '0;
            r_tag_vld <= 1'b0;
        end else begin
            r_tag_vld <= 1'b0;
            if ((r_state == S_BURST) && !w_abort) begin
                r_w       <= w_sel_w;
                r_j       <= w_sel_j;
                r_tag     <= r_last;
                r_tag_vld <= 1'b1;
            end
        end
    end

    // Return path: capture Cost one edge after its address was sampled
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cost     <= '0;
            r_cost_vld <= '0;
        end else begin
            if (r_tag_vld) begin
                r_cost     <= Cost;
                r_cost_vld <= w_tag_onehot;
            end else begin
                r_cost_vld <= '0;
            end
        end
    end

    assign gnt      = r_gnt;
    assign beat     = r_beat;
    assign W        = r_w;
    assign J        = r_j;
    assign cost_out = r_cost;
    assign cost_vld = r_cost_vld;
    assign busy     = w_busy;

endmodule
